carfield_boot_sequencer: RTL and testbench

CARFIELD_BOOT_SEQUENCER -- requirements
Module: carfield_soc_fixture

---
 rtl/carfield_boot_sequencer.sv | 165 ++++++++++++++++
 tb/tb_carfield_boot_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/carfield_boot_sequencer.sv
// Boot sequencer for the Carfield SoC fixture: selects a debug/preload path from the
// captured boot and preload modes, handshakes init and load with the SoC side, then
// polls the end-of-computation register and reports the program exit code.
module carfield_boot_sequencer #(
    parameter int unsigned JTAG_DELAY = 120000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  boot_mode,
    input  logic [1:0]  preload_mode,
    input  logic        start,
    output logic        init_req,
    input  logic        init_ack,
    output logic        load_req,
    output logic [1:0]  load_chan,
    input  logic        load_ack,
    input  logic [31:0] eoc_reg,
    output logic        busy,
    output logic        finish,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [31:0] exit_code
);

    // Counter runs 0 .. JTAG_DELAY-1; with JTAG_DELAY=0 the DELAY state is never entered.
    localparam int unsigned CntW = (JTAG_DELAY > 1) ? $clog2(JTAG_DELAY) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(JTAG_DELAY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StInit,
        StLoad,
        StPoll,
        StDone,
        StErr
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      boot_q, boot_d;
    logic [1:0]      load_chan_q, load_chan_d;
    logic            finish_q, finish_d;
    logic            error_q, error_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [31:0]     exit_code_q, exit_code_d;
    logic            busy_q, init_req_q, load_req_q;

    // Next-state and next-value logic for the sequencer and its sticky status outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        boot_d      = boot_q;
        load_chan_d = load_chan_q;
        finish_d    = finish_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        exit_code_d = exit_code_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    boot_d      = boot_mode;
                    load_chan_d = 2'd0;
                    finish_d    = 1'b0;
                    error_d     = 1'b0;
                    err_code_d  = 2'd0;
                    exit_code_d = '0;
                    unique case (boot_mode)
                        2'd0: begin
                            unique case (preload_mode)
                                2'd0: state_d = (JTAG_DELAY == 0) ? StInit : StDelay;
                                2'd1, 2'd2: begin
                                    state_d     = StLoad;
                                    load_chan_d = preload_mode;
                                end
                                default: begin
                                    state_d    = StErr;
                                    finish_d   = 1'b1;
                                    error_d    = 1'b1;
                                    err_code_d = 2'd2;
                                end
                            endcase
                        end
                        2'd1: begin
                            state_d    = StErr;
                            finish_d   = 1'b1;
                            error_d    = 1'b1;
                            err_code_d = 2'd1;
                        end
                        default: state_d = StInit;
                    endcase
                end
            end
            StDelay: begin
                if (cnt_q == LastCnt) begin
                    state_d = StInit;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StInit: begin
                // Only the JTAG preload path (boot mode 0) loads a binary after init.
                if (init_ack) begin
                    state_d = (boot_q == 2'd0) ? StLoad : StPoll;
                end
            end
            StLoad: begin
                if (load_ack) begin
                    state_d = StPoll;
                end
            end
            StPoll: begin
                if (eoc_reg[0]) begin
                    exit_code_d = {1'b0, eoc_reg[31:1]};
                    finish_d    = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, counter and output registers; request/busy flops track the next state so
    // they line up cycle-for-cycle with the registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            boot_q      <= 2'd0;
            load_chan_q <= 2'd0;
            finish_q    <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'd0;
            exit_code_q <= '0;
            busy_q      <= 1'b0;
            init_req_q  <= 1'b0;
            load_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            boot_q      <= boot_d;
            load_chan_q <= load_chan_d;
            finish_q    <= finish_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            exit_code_q <= exit_code_d;
            busy_q      <= (state_d != StIdle);
            init_req_q  <= (state_d == StInit);
            load_req_q  <= (state_d == StLoad);
        end
    end

    assign busy      = busy_q;
    assign init_req  = init_req_q;
    assign load_req  = load_req_q;
    assign load_chan = load_chan_q;
    assign finish    = finish_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign exit_code = exit_code_q;

endmodule

// File: tb/tb_carfield_boot_sequencer.sv
// Self-checking bench for carfield_boot_sequencer: each boot is summarised as phase
// lengths and final status, predicted from the mode table and handshake latencies.
module tb_carfield_boot_sequencer;

    localparam int DLY = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  boot_mode;
    logic [1:0]  preload_mode;
    logic        start;
    logic        init_req;
    logic        init_ack;
    logic        load_req;
    logic [1:0]  load_chan;
    logic        load_ack;
    logic [31:0] eoc_reg;
    logic        busy;
    logic        finish;
    logic        error;
    logic [1:0]  err_code;
    logic [31:0] exit_code;

    int n_vec;
    int n_bad;

    carfield_boot_sequencer #(
        .JTAG_DELAY(DLY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .boot_mode   (boot_mode),
        .preload_mode(preload_mode),
        .start       (start),
        .init_req    (init_req),
        .init_ack    (init_ack),
        .load_req    (load_req),
        .load_chan   (load_chan),
        .load_ack    (load_ack),
        .eoc_reg     (eoc_reg),
        .busy        (busy),
        .finish      (finish),
        .error       (error),
        .err_code    (err_code),
        .exit_code   (exit_code)
    );

    always #5 clk = ~clk;

    // One boot from start to return-to-idle; checks phase lengths and final status.
    task automatic run_seq(input logic [1:0] b, input logic [1:0] p, input int ilat,
                           input int llat, input int plat, input logic [31:0] eoc,
                           input string tag);
        logic [1:0]  exp_err;
        logic [31:0] exp_exit;
        logic [31:0] r;
        bit          ok_path;
        bit          done;
        int exp_delay, exp_init, exp_load, exp_poll, exp_busy;
        int busy_cyc, fin_cyc, stale, init_cyc, load_cyc, dly_cyc, poll_cyc, chan_bad, cyc;

        exp_err   = (b == 2'd1) ? 2'd1 : ((b == 2'd0 && p == 2'd3) ? 2'd2 : 2'd0);
        ok_path   = (exp_err == 2'd0);
        exp_delay = (b == 2'd0 && p == 2'd0) ? DLY : 0;
        exp_init  = (ok_path && (b != 2'd0 || p == 2'd0)) ? ilat + 1 : 0;
        exp_load  = (ok_path && b == 2'd0) ? llat + 1 : 0;
        exp_poll  = ok_path ? plat + 1 : 0;
        exp_busy  = exp_delay + exp_init + exp_load + exp_poll + 1;
        exp_exit  = ok_path ? (eoc >> 1) : 32'd0;

        busy_cyc = 0; fin_cyc = 0; stale = 0; init_cyc = 0; load_cyc = 0;
        dly_cyc = 0; poll_cyc = 0; chan_bad = 0; cyc = 0; done = 0;

        @(negedge clk);
        boot_mode = b; preload_mode = p; start = 1'b1;
        init_ack = 1'b0; load_ack = 1'b0; eoc_reg = 32'd0;
        @(negedge clk);
        while (!done && cyc < 400) begin
            if (!busy) begin
                done = 1;
            end else begin
                busy_cyc++;
                if (finish) fin_cyc++;
                else if (error || err_code != 2'd0 || exit_code != 32'd0) stale++;
                if (init_req) init_cyc++;
                if (load_req) begin
                    load_cyc++;
                    if (load_chan !== p) chan_bad++;
                end
                if (!init_req && !load_req && !finish) begin
                    if (init_cyc == 0 && load_cyc == 0) dly_cyc++;
                    else poll_cyc++;
                end
            end
            if (!done) begin
                // Ignored while busy: stray starts, mode changes and out-of-state acks.
                start        = ($urandom_range(0, 3) == 0);
                boot_mode    = 2'($urandom);
                preload_mode = 2'($urandom);
                init_ack     = init_req ? (init_cyc == ilat + 1) : 1'($urandom);
                load_ack     = load_req ? (load_cyc == llat + 1) : 1'($urandom);
                r = $urandom;
                if (!init_req && !load_req && !finish && (init_cyc > 0 || load_cyc > 0))
                    eoc_reg = (poll_cyc == plat + 1) ? eoc : {r[31:1], 1'b0};
                else
                    eoc_reg = r;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0; init_ack = 1'b0; load_ack = 1'b0;

        n_vec++; if (!done) begin n_bad++; $display("FAIL %s timeout: busy never dropped after %0d cycles", tag, cyc); end
        n_vec++; if (busy_cyc !== exp_busy) begin n_bad++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cyc, exp_busy); end
        n_vec++; if (dly_cyc !== exp_delay) begin n_bad++; $display("FAIL %s delay_cycles: got %0d expected %0d", tag, dly_cyc, exp_delay); end
        n_vec++; if (init_cyc !== exp_init) begin n_bad++; $display("FAIL %s init_req_cycles: got %0d expected %0d", tag, init_cyc, exp_init); end
        n_vec++; if (load_cyc !== exp_load) begin n_bad++; $display("FAIL %s load_req_cycles: got %0d expected %0d", tag, load_cyc, exp_load); end
        n_vec++; if (poll_cyc !== exp_poll) begin n_bad++; $display("FAIL %s poll_cycles: got %0d expected %0d", tag, poll_cyc, exp_poll); end
        n_vec++; if (fin_cyc !== 1) begin n_bad++; $display("FAIL %s finish_while_busy: got %0d cycles expected 1", tag, fin_cyc); end
        n_vec++; if (chan_bad !== 0) begin n_bad++; $display("FAIL %s load_chan: %0d bad cycles expected chan %0d", tag, chan_bad, p); end
        n_vec++; if (stale !== 0) begin n_bad++; $display("FAIL %s stale_status: %0d cycles with old status, expected 0", tag, stale); end
        n_vec++; if (finish !== 1'b1) begin n_bad++; $display("FAIL %s finish: got %b expected 1", tag, finish); end
        n_vec++; if (error !== (exp_err != 2'd0)) begin n_bad++; $display("FAIL %s error: got %b expected %b", tag, error, exp_err != 2'd0); end
        n_vec++; if (err_code !== exp_err) begin n_bad++; $display("FAIL %s err_code: got %0d expected %0d", tag, err_code, exp_err); end
        n_vec++; if (exit_code !== exp_exit) begin n_bad++; $display("FAIL %s exit_code: got %h expected %h", tag, exit_code, exp_exit); end
        n_vec++; if ({init_req, load_req} !== 2'b00) begin n_bad++; $display("FAIL %s reqs_idle: got %b expected 00", tag, {init_req, load_req}); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; init_ack = 1'b1; load_ack = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, init_req, load_req, finish, error, err_code, load_chan, exit_code} !== 39'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b init=%b load=%b fin=%b err=%b code=%0d chan=%0d exit=%h expected all 0",
                     busy, init_req, load_req, finish, error, err_code, load_chan, exit_code);
        end
        rst = 1'b0; start = 1'b0; init_ack = 1'b0; load_ack = 1'b0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_jtag();
        run_seq(2'd0, 2'd0, 2, 3, 2, 32'h0000_0001, "jtag");
    endtask

    task automatic test_serial();
        run_seq(2'd0, 2'd1, 0, 2, 1, 32'h0000_000B, "serial");
    endtask

    task automatic test_uart();
        run_seq(2'd0, 2'd2, 0, 1, 0, 32'hDEAD_BEEF, "uart");
    endtask

    task automatic test_autonomous();
        run_seq(2'd2, 2'd1, 1, 0, 3, 32'h0000_0003, "auto2");
        run_seq(2'd3, 2'd3, 0, 0, 0, 32'hFFFF_FFFF, "auto3");
    endtask

    task automatic test_errors();
        run_seq(2'd1, 2'd0, 0, 0, 0, 32'd0, "sd_card");
        run_seq(2'd0, 2'd3, 0, 0, 0, 32'd0, "reserved_preload");
    endtask

    task automatic test_back_to_back();
        run_seq(2'd0, 2'd1, 1, 1, 1, 32'h1234_5679, "b2b_a");
        run_seq(2'd1, 2'd2, 0, 0, 0, 32'd0, "b2b_b");
        run_seq(2'd2, 2'd0, 0, 0, 0, 32'h0000_0081, "b2b_c");
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int i = 0; i < 20; i++) begin
            e = $urandom;
            run_seq(2'($urandom), 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 4), e | 32'd1, "random");
        end
    endtask

    // Reset mid-sequence (in DELAY or in LOAD), then a full JTAG boot must run cleanly.
    task automatic test_reset_mid(input bit in_load);
        int  cyc;
        bit  hit;
        cyc = 0; hit = 0;
        @(negedge clk);
        boot_mode = 2'd0; preload_mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!hit && cyc < 60) begin
            if (in_load ? load_req : (cyc == 2)) hit = 1;
            else begin
                init_ack = init_req;
                load_ack = 1'b0;
                eoc_reg  = 32'd0;
                @(negedge clk);
                cyc++;
            end
        end
        n_vec++; if (!hit) begin n_bad++; $display("FAIL reset_mid_reach: target phase not reached in %0d cycles", cyc); end
        rst = 1'b1; start = 1'b1; init_ack = 1'b1; load_ack = 1'b1; eoc_reg = 32'hFFFF_FFFF;
        @(negedge clk);
        n_vec++;
        if ({busy, init_req, load_req, finish, error, err_code, load_chan, exit_code} !== 39'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got busy=%b init=%b load=%b fin=%b err=%b code=%0d chan=%0d exit=%h expected all 0",
                     busy, init_req, load_req, finish, error, err_code, load_chan, exit_code);
        end
        rst = 1'b0; start = 1'b0; init_ack = 1'b0; load_ack = 1'b0; eoc_reg = 32'd0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid_idle: busy got %b expected 0", busy); end
        run_seq(2'd0, 2'd0, 1, 1, 1, 32'h0000_0015, in_load ? "after_rst_load" : "after_rst_delay");
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        clk = 1'b0; rst = 1'b1; start = 1'b0; boot_mode = 2'd0; preload_mode = 2'd0;
        init_ack = 1'b0; load_ack = 1'b0; eoc_reg = 32'd0;
        test_reset();
        test_jtag();
        test_serial();
        test_uart();
        test_autonomous();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
